// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared definitions for the digit-serial adder.
//   sa_state_t - FSM state encoding (IDLE, SHIFT, DONE)
//   clog2      - ceiling log2, sizes the digit counter
//   digit_ok   - configuration check, WIDTH must be a positive multiple of DIGIT
package serial_adder_pkg;

   typedef enum logic [1:0] {
      SA_IDLE  = 2'd0,
      SA_SHIFT = 2'd1,
      SA_DONE  = 2'd2
   } sa_state_t;

   function automatic int clog2(input int unsigned v);
      int          r;
      int unsigned x;
      r = 0;
      x = (v > 0) ? v - 1 : 0;
      while (x > 0) begin
         r++;
         x = x >> 1;
      end
      return r;
   endfunction

   function automatic bit digit_ok(input int w, input int d);
      return (d > 0) && (w >= d) && ((w % d) == 0);
   endfunction

endpackage

// File: rtl/adder_digit.sv
// adder_digit: combinational DIGIT-bit ripple-carry adder.
//   a, b  - DIGIT-bit addends
//   cin   - carry in
//   s     - DIGIT-bit sum
//   cout  - carry out of the top bit
//   c_top - carry into the top bit (cout ^ c_top gives signed overflow)
module adder_digit #(
   parameter int DIGIT = 1
) (
   input  logic [DIGIT-1:0] a,
   input  logic [DIGIT-1:0] b,
   input  logic             cin,
   output logic [DIGIT-1:0] s,
   output logic             cout,
   output logic             c_top
);

   logic c;

   always_comb begin
      c     = cin;
      s     = '0;
      c_top = cin;
      for (int unsigned i = 0; i < DIGIT; i++) begin
         if (i == DIGIT - 1) c_top = c;
         s[i] = a[i] ^ b[i] ^ c;
         c    = (a[i] & b[i]) | (a[i] & c) | (b[i] & c);
      end
      cout = c;
   end

endmodule

// File: rtl/serial_adder_param.sv
// serial_adder_param: digit-serial adder with start/done handshake.
//   Loads A and B on an accepted start, then adds DIGIT bits per clock from
//   the LSB through a carry flip-flop. Result is held from done until the
//   next accepted start.
//   clk, clear      - clock, synchronous active-high reset
//   start           - request, sampled only in IDLE
//   a, b, sub       - operands and subtract select, captured on start
//   busy, done      - processing flag, one-cycle result-valid pulse
//   sum, cout, ovf  - result, final carry (1 = no borrow), signed overflow
//   ser_sum         - digit formed this cycle, valid when ser_valid (= busy)
// Build option: define SERIAL_SUB_EN to enable A-B via the sub input;
// otherwise sub is ignored and only addition is built.
module serial_adder_param
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DIGIT = 1
) (
   input  logic             clk,
   input  logic             clear,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic [DIGIT-1:0] ser_sum,
   output logic             ser_valid
);

   localparam int NDIG  = WIDTH / DIGIT;
   localparam int CNT_W = (clog2(NDIG) > 0) ? clog2(NDIG) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(NDIG - 1);

   if (!digit_ok(WIDTH, DIGIT)) begin : g_cfg_err
      $error("serial_adder_param: WIDTH must be a positive multiple of DIGIT");
   end

   sa_state_t        state, state_nx;
   logic [WIDTH-1:0] a_sr, b_sr, sum_sr, sum_nx;
   logic [CNT_W-1:0] cnt;
   logic             carry;
   logic             cout_r, ovf_r;
   logic             sub_eff;
   logic [DIGIT-1:0] b_dig, d_sum;
   logic             d_cout, d_ctop;
   logic             accept, last_dig;

   assign accept   = (state == SA_IDLE) && start;
   assign last_dig = (cnt == LAST);

`ifdef SERIAL_SUB_EN
   logic sub_r;

   always_ff @(posedge clk) begin
      if (clear)       sub_r <= 1'b0;
      else if (accept) sub_r <= sub;
   end

   // Two's complement subtract: B inverted digit by digit, carry preset to 1.
   assign sub_eff = sub_r;
   assign b_dig   = b_sr[DIGIT-1:0] ^ {DIGIT{sub_r}};
`else
   logic unused_sub;
   assign unused_sub = sub;
   assign sub_eff    = 1'b0;
   assign b_dig      = b_sr[DIGIT-1:0];
`endif

   adder_digit #(.DIGIT(DIGIT)) u_digit (
      .a     (a_sr[DIGIT-1:0]),
      .b     (b_dig),
      .cin   (carry),
      .s     (d_sum),
      .cout  (d_cout),
      .c_top (d_ctop)
   );

   // New digit enters at the MSB end; after NDIG digits the LSB digit is at bit 0.
   always_comb begin
      sum_nx                    = sum_sr >> DIGIT;
      sum_nx[WIDTH-1 -: DIGIT]  = d_sum;
   end

   always_ff @(posedge clk) begin
      if (clear) state <= SA_IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         SA_IDLE:  if (start)    state_nx = SA_SHIFT;
         SA_SHIFT: if (last_dig) state_nx = SA_DONE;
         SA_DONE:                state_nx = SA_IDLE;
         default:                state_nx = SA_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (clear) begin
         a_sr   <= '0;
         b_sr   <= '0;
         sum_sr <= '0;
         cnt    <= '0;
         carry  <= 1'b0;
         cout_r <= 1'b0;
         ovf_r  <= 1'b0;
      end else if (accept) begin
         a_sr   <= a;
         b_sr   <= b;
         sum_sr <= '0;
         cnt    <= '0;
         carry  <= sub_eff_next();
         cout_r <= 1'b0;
         ovf_r  <= 1'b0;
      end else if (state == SA_SHIFT) begin
         a_sr   <= a_sr >> DIGIT;
         b_sr   <= b_sr >> DIGIT;
         sum_sr <= sum_nx;
         cnt    <= cnt + 1'b1;
         carry  <= d_cout;
         if (last_dig) begin
            cout_r <= d_cout;
            ovf_r  <= d_ctop ^ d_cout;
         end
      end
   end

   // Carry preset must follow the sub value being captured on this same edge.
   function automatic logic sub_eff_next();
`ifdef SERIAL_SUB_EN
      return sub;
`else
      return sub_eff;
`endif
   endfunction

   assign busy      = (state == SA_SHIFT);
   assign done      = (state == SA_DONE);
   assign ser_valid = busy;
   assign ser_sum   = busy ? d_sum : '0;
   assign sum       = sum_sr;
   assign cout      = cout_r;
   assign ovf       = ovf_r;

endmodule

// File: tb/tb_serial_adder_param.sv
module tb_serial_adder_param;

   logic       clk = 1'b0;
   logic       clear;
   logic       start1, start4;
   logic [7:0] a1, b1, a4, b4;
   logic       sub1, sub4;
   logic       busy1, done1, cout1, ovf1, ser_valid1;
   logic       busy4, done4, cout4, ovf4, ser_valid4;
   logic [7:0] sum1, sum4;
   logic [0:0] ser1;
   logic [3:0] ser4;

   always #5 clk = ~clk;

   serial_adder_param #(.WIDTH(8), .DIGIT(1)) u_d1 (
      .clk(clk), .clear(clear), .start(start1), .a(a1), .b(b1), .sub(sub1),
      .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .ovf(ovf1),
      .ser_sum(ser1), .ser_valid(ser_valid1)
   );

   serial_adder_param #(.WIDTH(8), .DIGIT(4)) u_d4 (
      .clk(clk), .clear(clear), .start(start4), .a(a4), .b(b4), .sub(sub4),
      .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .ovf(ovf4),
      .ser_sum(ser4), .ser_valid(ser_valid4)
   );

   // Muxed view of whichever instance the current test drives.
   logic       sel4;
   logic       busy_m, done_m, cout_m, ovf_m, sv_m;
   logic [7:0] sum_m;
   logic [3:0] ser_m;
   assign busy_m = sel4 ? busy4 : busy1;
   assign done_m = sel4 ? done4 : done1;
   assign cout_m = sel4 ? cout4 : cout1;
   assign ovf_m  = sel4 ? ovf4  : ovf1;
   assign sv_m   = sel4 ? ser_valid4 : ser_valid1;
   assign sum_m  = sel4 ? sum4  : sum1;
   assign ser_m  = sel4 ? ser4  : {3'b000, ser1};

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       sub;
      logic [7:0] s;
      logic       c;
      logic       v;
   } vec_t;

   vec_t vecs[9];

   task automatic drive(input logic use4, input logic st, input logic [7:0] av,
                        input logic [7:0] bv, input logic sv);
      if (use4) begin start4 = st; a4 = av; b4 = bv; sub4 = sv; end
      else      begin start1 = st; a1 = av; b1 = bv; sub1 = sv; end
   endtask

   // One operation from an idle DUT: latency, busy length, streamed digits,
   // result flags, one-cycle done and held result.
   task automatic run_op(input logic use4, input vec_t v, input string tag);
      int         ndig, dw, cyc, nbusy, idx;
      logic [7:0] acc;
      ndig  = use4 ? 2 : 8;
      dw    = use4 ? 4 : 1;
      nbusy = 0;
      idx   = 0;
      acc   = '0;
      sel4  = use4;
      @(negedge clk);
      drive(use4, 1'b1, v.a, v.b, v.sub);
      @(negedge clk);
      // Operands change after acceptance and must have no effect.
      drive(use4, 1'b0, ~v.a, ~v.b, ~v.sub);
      for (cyc = 1; cyc <= 40; cyc++) begin
         if (done_m) break;
         if (busy_m) nbusy++;
         if (sv_m) begin
            acc = acc | (8'(ser_m) << (dw * idx));
            idx++;
         end
         @(negedge clk);
      end
      check({tag, " latency"}, cyc, ndig + 1);
      check({tag, " busy_cycles"}, nbusy, ndig);
      check({tag, " ser_stream"}, acc, v.s);
      check({tag, " sum"}, sum_m, v.s);
      check({tag, " cout"}, cout_m, v.c);
      check({tag, " ovf"}, ovf_m, v.v);
      @(negedge clk);
      check({tag, " done_pulse"}, done_m, 0);
      check({tag, " sum_held"}, sum_m, v.s);
   endtask

   initial begin
      int         ndone;
      logic [7:0] sum_at_done;

      vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1};
      vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
      vecs[2] = '{8'h27, 8'h19, 1'b0, 8'h40, 1'b0, 1'b0};
      vecs[3] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
      vecs[4] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
      vecs[5] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
`ifdef SERIAL_SUB_EN
      vecs[6] = '{8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0};
      vecs[7] = '{8'h50, 8'h30, 1'b1, 8'h20, 1'b1, 1'b0};
      vecs[8] = '{8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1};
`else
      vecs[6] = '{8'h10, 8'h20, 1'b1, 8'h30, 1'b0, 1'b0};
      vecs[7] = '{8'h50, 8'h30, 1'b1, 8'h80, 1'b0, 1'b1};
      vecs[8] = '{8'h80, 8'h01, 1'b1, 8'h81, 1'b0, 1'b0};
`endif

      sel4  = 1'b0;
      clear = 1'b1;
      drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
      drive(1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
      repeat (2) @(negedge clk);
      check("reset busy1", busy1, 0);
      check("reset done1", done1, 0);
      check("reset sum1", sum1, 0);
      check("reset flags1", {cout1, ovf1, ser1, ser_valid1}, 0);
      check("reset busy4", busy4, 0);
      check("reset sum4", sum4, 0);
      check("reset flags4", {done4, cout4, ovf4, ser4, ser_valid4}, 0);
      clear = 1'b0;

      foreach (vecs[i]) run_op(1'b0, vecs[i], $sformatf("d1 v%0d", i));
      foreach (vecs[i]) run_op(1'b1, vecs[i], $sformatf("d4 v%0d", i));

      // Start re-pulsed during SHIFT with other operands: ignored, one done.
      sel4 = 1'b0;
      @(negedge clk);
      drive(1'b0, 1'b1, 8'h5A, 8'h3C, 1'b0);
      @(negedge clk);
      ndone       = 0;
      sum_at_done = '0;
      for (int c = 1; c <= 16; c++) begin
         if (c == 3) drive(1'b0, 1'b1, 8'h11, 8'h22, 1'b0);
         else        start1 = 1'b0;
         if (done1) begin
            ndone++;
            sum_at_done = sum1;
         end
         @(negedge clk);
      end
      check("restart done_count", ndone, 1);
      check("restart sum", sum_at_done, 8'h96);

      // Clear in the 4th SHIFT cycle aborts without a done.
      @(negedge clk);
      drive(1'b0, 1'b1, 8'h5A, 8'h3C, 1'b0);
      @(negedge clk);
      start1 = 1'b0;
      repeat (3) @(negedge clk);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      check("abort busy", busy1, 0);
      check("abort sum", sum1, 0);
      check("abort flags", {done1, cout1, ovf1, ser1, ser_valid1}, 0);
      ndone = 0;
      for (int c = 0; c < 12; c++) begin
         if (done1) ndone++;
         @(negedge clk);
      end
      check("abort no_done", ndone, 0);
      run_op(1'b0, vecs[4], "after_abort");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
